// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and state encoding for the fetch unit
package fetch_pkg;

   localparam logic [1:0] MNONE  = 2'b00;
   localparam logic [1:0] MREAD  = 2'b01;
   localparam logic [1:0] MWRITE = 2'b10;

   localparam logic [1:0] PC_INC  = 2'b00;
   localparam logic [1:0] PC_REL  = 2'b01;
   localparam logic [1:0] PC_ABS  = 2'b10;
   localparam logic [1:0] PC_HALT = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_DACC,
      S_HALT
   } state_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - load-enable register with async active-low reset and reset value
module fetch_pc_reg #(
   parameter int           W       = 9,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] val_q;

   // hold value unless loaded; reset forces the configured value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val_q <= RST_VAL;
      end else if (en) begin
         val_q <= d;
      end
   end

   assign q = val_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC/IR owner and fetch vs data-access memory sequencer (watchdog: FETCH_WDOG_EN)
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = 9,
   parameter int                DATA_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                TIMEOUT  = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              go,
   input  logic              exec_done,
   input  logic [1:0]        pc_sel,
   input  logic [DATA_W-1:0] off,
   input  logic [ADDR_W-1:0] target,
   input  logic              dat_req,
   input  logic              dat_we,
   input  logic [ADDR_W-1:0] dat_addr,
   input  logic [DATA_W-1:0] dat_wdata,
   input  logic              mem_rdy,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        mem_cmd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [DATA_W-1:0] ir,
   output logic              ir_valid,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] link,
   output logic [DATA_W-1:0] dat_rdata,
   output logic              dat_done,
   output logic              halted,
   output logic              mem_err
);

   state_t            state_q, state_d;
   logic              dacc_we_q, dacc_we_d;
   logic [ADDR_W-1:0] dacc_addr_q, dacc_addr_d;
   logic [DATA_W-1:0] dacc_wdata_q, dacc_wdata_d;
   logic [DATA_W-1:0] dat_rdata_q, dat_rdata_d;
   logic              dat_done_q, dat_done_d;
   logic              mem_err_q, mem_err_d;
   logic              pc_en, ir_en, link_en;
   logic [ADDR_W-1:0] pc_d, pc_inc;
   logic              off_unused;

   // only the low ADDR_W bits of the offset matter; the rest is sign extension
   assign off_unused = ^off;
   assign pc_inc     = pc + ADDR_W'(1);

   fetch_pc_reg #(.W(ADDR_W), .RST_VAL(RESET_PC)) u_pc (
      .clk(clk), .rst_n(reset), .en(pc_en), .d(pc_d), .q(pc)
   );
   fetch_pc_reg #(.W(DATA_W), .RST_VAL('0)) u_ir (
      .clk(clk), .rst_n(reset), .en(ir_en), .d(mem_rdata), .q(ir)
   );
   fetch_pc_reg #(.W(ADDR_W), .RST_VAL('0)) u_link (
      .clk(clk), .rst_n(reset), .en(link_en), .d(pc_inc), .q(link)
   );

`ifdef FETCH_WDOG_EN
   localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [WD_W-1:0] wdog_q, wdog_d;

   // wait-cycle counter: zero on every state change or completed command
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wdog_q <= '0;
      end else begin
         wdog_q <= wdog_d;
      end
   end
`else
   logic wdog_unused;
   assign wdog_unused = (TIMEOUT > 0);
`endif

   // sequencer state and data-access registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         dacc_we_q    <= 1'b0;
         dacc_addr_q  <= '0;
         dacc_wdata_q <= '0;
         dat_rdata_q  <= '0;
         dat_done_q   <= 1'b0;
         mem_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         dacc_we_q    <= dacc_we_d;
         dacc_addr_q  <= dacc_addr_d;
         dacc_wdata_q <= dacc_wdata_d;
         dat_rdata_q  <= dat_rdata_d;
         dat_done_q   <= dat_done_d;
         mem_err_q    <= mem_err_d;
      end
   end

   // next state, PC/IR/link loads; a data request in EXEC wins over exec_done
   always_comb begin
      state_d      = state_q;
      dacc_we_d    = dacc_we_q;
      dacc_addr_d  = dacc_addr_q;
      dacc_wdata_d = dacc_wdata_q;
      dat_rdata_d  = dat_rdata_q;
      dat_done_d   = 1'b0;
      mem_err_d    = mem_err_q;
      pc_en        = 1'b0;
      pc_d         = pc;
      ir_en        = 1'b0;
      link_en      = 1'b0;
      case (state_q)
         S_IDLE:   if (go) state_d = S_FETCH;
         S_FETCH: begin
            if (mem_rdy) begin
               ir_en   = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            pc_en   = 1'b1;
            pc_d    = pc_inc;
            link_en = 1'b1;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            if (dat_req) begin
               dacc_we_d    = dat_we;
               dacc_addr_d  = dat_addr;
               dacc_wdata_d = dat_wdata;
               state_d      = S_DACC;
            end else if (exec_done) begin
               case (pc_sel)
                  PC_INC: state_d = S_FETCH;
                  PC_REL: begin
                     pc_en   = 1'b1;
                     pc_d    = pc + off[ADDR_W-1:0];
                     state_d = S_FETCH;
                  end
                  PC_ABS: begin
                     pc_en   = 1'b1;
                     pc_d    = target;
                     state_d = S_FETCH;
                  end
                  default: state_d = S_HALT;
               endcase
            end
         end
         S_DACC: begin
            if (mem_rdy) begin
               if (!dacc_we_q) dat_rdata_d = mem_rdata;
               dat_done_d = 1'b1;
               state_d    = S_EXEC;
            end
         end
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_IDLE;
      endcase
`ifdef FETCH_WDOG_EN
      wdog_d = '0;
      if ((state_q == S_FETCH || state_q == S_DACC) && !mem_rdy) begin
         if (wdog_q == WD_W'(TIMEOUT - 1)) begin
            state_d   = S_HALT;
            mem_err_d = 1'b1;
         end else begin
            wdog_d = wdog_q + WD_W'(1);
         end
      end
`endif
   end

   // memory bus is a pure function of state and latched registers
   always_comb begin
      mem_cmd   = MNONE;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state_q)
         S_FETCH: begin
            mem_cmd  = MREAD;
            mem_addr = pc;
         end
         S_DACC: begin
            mem_cmd   = dacc_we_q ? MWRITE : MREAD;
            mem_addr  = dacc_addr_q;
            mem_wdata = dacc_we_q ? dacc_wdata_q : '0;
         end
         default: mem_cmd = MNONE;
      endcase
   end

   assign ir_valid  = (state_q == S_DECODE);
   assign halted    = (state_q == S_HALT);
   assign dat_rdata = dat_rdata_q;
   assign dat_done  = dat_done_q;
`ifdef FETCH_WDOG_EN
   assign mem_err   = mem_err_q;
`else
   assign mem_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized scoreboard bench for fetch_unit (honours FETCH_WDOG_EN)
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam int AW = 9;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset, go, exec_done, dat_req, dat_we, mem_rdy;
   logic [1:0]    pc_sel;
   logic [DW-1:0] off, dat_wdata, mem_rdata;
   logic [AW-1:0] target, dat_addr;
   logic [1:0]    mem_cmd;
   logic [AW-1:0] mem_addr, pc, link;
   logic [DW-1:0] mem_wdata, ir, dat_rdata;
   logic          ir_valid, dat_done, halted, mem_err;

   always #5 clk = ~clk;

   fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(9'd0), .TIMEOUT(15)) dut (
      .clk(clk), .reset(reset), .go(go), .exec_done(exec_done), .pc_sel(pc_sel),
      .off(off), .target(target), .dat_req(dat_req), .dat_we(dat_we),
      .dat_addr(dat_addr), .dat_wdata(dat_wdata), .mem_rdy(mem_rdy),
      .mem_rdata(mem_rdata), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .ir(ir), .ir_valid(ir_valid), .pc(pc), .link(link),
      .dat_rdata(dat_rdata), .dat_done(dat_done), .halted(halted), .mem_err(mem_err)
   );

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          exp_ir[$];
   exp_t          exp_dat[$];
   logic [DW-1:0] model_mem[512];
   logic [DW-1:0] env_mem[512];
   logic [AW-1:0] cur_pc;
   int            tests = 0;
   int            fails = 0;
   int            wait_mode = 0;   // 0 random waits, 1 fixed_wait, 2 never ready
   int            fixed_wait = 0;
   bit            pend = 1'b0;
   logic [AW-1:0] pend_pc;
   logic [AW-1:0] wr_addr_seen;
   logic [DW-1:0] wr_data_seen;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_t e;
      e.we = we; e.addr = a; e.data = d;
      return e;
   endfunction

   // memory model: random or fixed wait states, spurious mem_rdy when idle
   initial begin : responder
      int            cnt;
      int            cur_wait;
      logic [1:0]    last_cmd;
      logic [AW-1:0] last_addr;
      logic [DW-1:0] last_wdata;
      cnt = 0; cur_wait = 0; last_cmd = MNONE; last_addr = '0; last_wdata = '0;
      mem_rdy = 1'b0; mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (mem_rdy && last_cmd == MWRITE && reset) begin
            env_mem[last_addr] = last_wdata;
            wr_addr_seen = last_addr;
            wr_data_seen = last_wdata;
         end
         if (mem_rdy || last_cmd == MNONE) begin
            cnt = 0;
            cur_wait = (wait_mode == 0) ? int'($urandom_range(0, 3)) : fixed_wait;
         end
         if (mem_cmd != MNONE) begin
            mem_rdy   = (wait_mode != 2) && (cnt >= cur_wait);
            cnt++;
            mem_rdata = env_mem[mem_addr];
         end else begin
            mem_rdy   = ($urandom_range(0, 1) == 1);
            mem_rdata = DW'($urandom);
         end
         last_cmd = mem_cmd; last_addr = mem_addr; last_wdata = mem_wdata;
      end
   end

   // scoreboard monitor: pops an expectation for every ir_valid / dat_done pulse
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk); #2;
         if (!reset) begin
            pend = 1'b0;
         end else begin
            if (pend) begin
               chk("link", 32'(link), 32'(pend_pc));
               chk("pc_after_decode", 32'(pc), 32'(pend_pc));
               pend = 1'b0;
            end
            if (ir_valid) begin
               if (exp_ir.size() == 0) begin
                  chk("ir_unexpected", 32'(1), 32'(0));
               end else begin
                  e = exp_ir.pop_front();
                  chk("ir", 32'(ir), 32'(e.data));
                  chk("pc_at_decode", 32'(pc), 32'(e.addr));
                  pend    = 1'b1;
                  pend_pc = e.addr + AW'(1);
               end
            end
            if (dat_done) begin
               if (exp_dat.size() == 0) begin
                  chk("dat_done_unexpected", 32'(1), 32'(0));
               end else begin
                  e = exp_dat.pop_front();
                  if (e.we) begin
                     chk("store_addr", 32'(wr_addr_seen), 32'(e.addr));
                     chk("store_data", 32'(wr_data_seen), 32'(e.data));
                  end else begin
                     chk("load_data", 32'(dat_rdata), 32'(e.data));
                  end
               end
            end
         end
      end
   end

   task automatic do_reset();
      reset = 1'b0; go = 1'b0; exec_done = 1'b0; dat_req = 1'b0; pc_sel = 2'b00;
      off = '0; target = '0; dat_we = 1'b0; dat_addr = '0; dat_wdata = '0;
      exp_ir.delete(); exp_dat.delete();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pc", 32'(pc), 32'(0));
      chk("rst_ir", 32'(ir), 32'(0));
      chk("rst_link", 32'(link), 32'(0));
      chk("rst_dat_rdata", 32'(dat_rdata), 32'(0));
      chk("rst_mem_cmd", 32'(mem_cmd), 32'(MNONE));
      chk("rst_mem_addr", 32'(mem_addr), 32'(0));
      chk("rst_mem_wdata", 32'(mem_wdata), 32'(0));
      chk("rst_flags", 32'({ir_valid, dat_done, halted, mem_err}), 32'(0));
      reset = 1'b1;
   endtask

   task automatic start();
      go = 1'b1;
      cur_pc = '0;
      exp_ir.push_back(mk(1'b0, '0, model_mem[0]));
      @(posedge clk); #1;
      go = 1'b0;
   endtask

   task automatic wait_exec();
      bit seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (ir_valid) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      chk("reach_decode", 32'(seen), 32'(1));
      if (seen) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic do_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      bit both = ($urandom_range(0, 3) == 0);
      bit seen = 1'b0;
      dat_req = 1'b1; dat_we = we; dat_addr = a; dat_wdata = d;
      exec_done = both; pc_sel = PC_HALT;
      exp_dat.push_back(mk(we, a, we ? d : model_mem[a]));
      if (we) model_mem[a] = d;
      @(posedge clk); #1;
      dat_req = 1'b0; exec_done = 1'b0;
      dat_we = 1'($urandom); dat_addr = AW'($urandom); dat_wdata = DW'($urandom);
      chk("dacc_cmd", 32'(mem_cmd), 32'(we ? MWRITE : MREAD));
      chk("dacc_addr", 32'(mem_addr), 32'(a));
      if (we) chk("dacc_wdata", 32'(mem_wdata), 32'(d));
      for (int i = 0; i < 100; i++) begin
         if (dat_done) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      chk("dat_done_seen", 32'(seen), 32'(1));
   endtask

   task automatic exec_instr(input logic [1:0] sel, input logic [DW-1:0] o,
                             input logic [AW-1:0] tgt, input int nacc);
      logic [AW-1:0] nxt;
      for (int k = 0; k < nacc; k++)
         do_access(1'($urandom), AW'($urandom), DW'($urandom));
      exec_done = 1'b1; pc_sel = sel; off = o; target = tgt;
      case (sel)
         2'b00:   nxt = cur_pc + AW'(1);
         2'b01:   nxt = cur_pc + AW'(1) + o[AW-1:0];
         2'b10:   nxt = tgt;
         default: nxt = cur_pc;
      endcase
      if (sel != 2'b11) exp_ir.push_back(mk(1'b0, nxt, model_mem[nxt]));
      cur_pc = nxt;
      @(posedge clk); #1;
      exec_done = 1'b0; pc_sel = 2'($urandom);
   endtask

   initial begin : watchdog_timer
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin : main
      int n;
      for (int i = 0; i < 512; i++) begin
         model_mem[i] = DW'($urandom);
         env_mem[i]   = model_mem[i];
      end
      model_mem[0] = 16'hD105; env_mem[0] = 16'hD105;
      wait_mode = 1; fixed_wait = 0;
      do_reset();

      start();
      chk("c1_cmd", 32'(mem_cmd), 32'(MREAD));
      chk("c1_addr", 32'(mem_addr), 32'(0));
      @(posedge clk); #1;
      chk("c2_ir_valid", 32'(ir_valid), 32'(1));
      chk("c2_ir", 32'(ir), 32'h0000_D105);
      @(posedge clk); #1;
      chk("c3_pc", 32'(pc), 32'(1));
      chk("c3_link", 32'(link), 32'(1));

      exec_instr(PC_ABS, '0, 9'd5, 0);   wait_exec();
      exec_instr(PC_REL, 16'hFFFD, '0, 0); wait_exec();
      chk("rel_branch_pc", 32'(pc), 32'(4));
      exec_instr(PC_ABS, '0, 9'd511, 0); wait_exec();
      exec_instr(PC_INC, '0, '0, 0);     wait_exec();
      chk("wrap_pc", 32'(pc), 32'(1));

      model_mem[9'h40] = 16'hBEEF; env_mem[9'h40] = 16'hBEEF;
      fixed_wait = 2;
      do_access(1'b0, 9'h40, '0);
      chk("load_beef", 32'(dat_rdata), 32'h0000_BEEF);
      do_access(1'b1, 9'h41, 16'h1234);
      @(posedge clk); #1;
      chk("store_landed", 32'(env_mem[9'h41]), 32'h0000_1234);

      fixed_wait = 3;
      exec_instr(PC_ABS, '0, 9'h10, 0);
      n = 0;
      for (int i = 0; i < 50; i++) begin
         if (ir_valid) break;
         if (mem_cmd == MREAD && mem_addr == 9'h10) n++;
         @(posedge clk); #1;
      end
      chk("read_hold_cycles", 32'(n), 32'(4));
      @(posedge clk); #1;

      wait_mode = 0;
      repeat (25) begin
         exec_instr(2'($urandom_range(0, 2)), DW'($urandom), AW'($urandom),
                    int'($urandom_range(0, 2)));
         wait_exec();
      end

      exec_instr(PC_HALT, '0, '0, 0);
      @(posedge clk); #1;
      chk("halted", 32'(halted), 32'(1));
      chk("halt_cmd", 32'(mem_cmd), 32'(MNONE));
      go = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      go = 1'b0;
      chk("halt_ignores_go", 32'({halted, mem_cmd}), 32'({1'b1, MNONE}));
      chk("ir_queue_drained", 32'(exp_ir.size()), 32'(0));
      chk("dat_queue_drained", 32'(exp_dat.size()), 32'(0));

      do_reset();
      start();
      wait_exec();
      wait_mode = 2;
      exec_instr(PC_ABS, '0, 9'h77, 0);
      chk("pre_rst_addr", 32'(mem_addr), 32'h77);
      @(posedge clk); #1;
      chk("pre_rst_cmd", 32'(mem_cmd), 32'(MREAD));
      #2 reset = 1'b0;
      #1;
      chk("async_rst_cmd", 32'(mem_cmd), 32'(MNONE));
      chk("async_rst_pc", 32'(pc), 32'(0));
      do_reset();

      start();
`ifdef FETCH_WDOG_EN
      repeat (14) @(posedge clk);
      #1;
      chk("wdog_c15_cmd", 32'(mem_cmd), 32'(MREAD));
      chk("wdog_c15_err", 32'(mem_err), 32'(0));
      @(posedge clk); #1;
      chk("wdog_err", 32'(mem_err), 32'(1));
      chk("wdog_halt", 32'(halted), 32'(1));
      chk("wdog_cmd", 32'(mem_cmd), 32'(MNONE));
`else
      repeat (99) @(posedge clk);
      #1;
      chk("nowdog_c100_cmd", 32'(mem_cmd), 32'(MREAD));
      chk("nowdog_c100_err", 32'({mem_err, halted}), 32'(0));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch and memory-access sequencer for the simple RISC CPU. It owns the program counter, instruction register and memory command/address bus, and arbitrates between instruction fetches and load/store data accesses from the execute FSM. Unlike the fixed 9-bit, zero-wait PC path it replaces, it supports configurable widths, multi-cycle memory via a ready handshake, relative and absolute branches, a link value and a halt state.

## Interface
- ADDR_W, 9: PC / memory address width
- DATA_W, 16: instruction and data width
- RESET_PC, 0: PC value after reset
- TIMEOUT, 15: max wait cycles for mem_rdy (only with watchdog compiled in)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- go  in  1  leave IDLE and start fetching
- exec_done  in  1  execute FSM finished current instruction
- pc_sel  in  2  next-PC source: 00 PC+1, 01 PC+1+off, 10 target, 11 halt
- off  in  DATA_W  sign-extended branch offset; low ADDR_W bits used
- target  in  ADDR_W  absolute branch target
- dat_req, dat_we  in  1 each  data access request / write (1) or read (0)
- dat_addr  in  ADDR_W  data address
- dat_wdata  in  DATA_W  store data
- mem_rdy  in  1  memory completes current command this cycle
- mem_rdata  in  DATA_W  memory read data
- mem_cmd  out  2  NONE/READ/WRITE
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  store data to memory
- ir  out  DATA_W  instruction register
- ir_valid  out  1  one-cycle pulse: new instruction in ir
- pc  out  ADDR_W  current PC
- link  out  ADDR_W  PC+1 of the current instruction
- dat_rdata  out  DATA_W  captured load data
- dat_done  out  1  one-cycle pulse: data access complete
- halted, mem_err  out  1 each  in HALT / watchdog fired

## Operation
- States: IDLE, FETCH, DECODE, EXEC, DACC, HALT.
- IDLE: mem_cmd=NONE; go=1 -> FETCH.
- FETCH: mem_cmd=READ, mem_addr=pc; on mem_rdy, ir<=mem_rdata -> DECODE.
- DECODE: ir_valid=1, link<=pc+1, pc<=pc+1 -> EXEC.
- EXEC: dat_req has priority over exec_done. dat_req=1 -> latch dat_we/dat_addr/dat_wdata -> DACC. Otherwise exec_done=1 applies pc_sel: 00 hold (already +1), 01 pc<=pc+off[ADDR_W-1:0], 10 pc<=target -> FETCH; 11 -> HALT.
- DACC: mem_cmd=WRITE or READ at latched address; on mem_rdy, dat_rdata<=mem_rdata (read only), dat_done pulse -> EXEC.
- HALT: mem_cmd=NONE, halted=1; exits only on reset.
- PC arithmetic modulo 2^ADDR_W; wrap silent (max+1 -> 0, negative offsets wrap).
- mem_cmd encoding: NONE 00, READ 01, WRITE 10.

## Timing
- Reset (async, immediate): state IDLE, pc=RESET_PC, ir=0, link=0, dat_rdata=0, mem_cmd=NONE, mem_addr=0, mem_wdata=0, all pulses/flags 0. Reset mid-access drops mem_cmd to NONE same instant.
- mem_cmd, mem_addr, mem_wdata are Moore outputs of state plus registers; stable while command held; command held until the edge at which mem_rdy=1 is sampled.
- mem_rdy ignored outside FETCH/DACC.
- Zero-wait memory: go at edge 0 -> FETCH cycle 1, DECODE cycle 2 (ir_valid), EXEC cycle 3. Each wait cycle adds one.
- Data access: EXEC -> DACC (>=1 cycle) -> EXEC; dat_done coincides with return edge.
- exec_done and dat_req together: access served, exec_done dropped; execute FSM must re-assert.
- pc updated on exec_done edge; next FETCH address is new pc.

## Configuration
- FETCH_WDOG_EN defined: cycle counter in FETCH/DACC; after TIMEOUT consecutive cycles without mem_rdy, mem_cmd->NONE, mem_err=1 (sticky), -> HALT. Counter clears on state entry.
- Undefined: no counter, mem_err tied 0, waits indefinitely.

## Structure
- Package fetch_pkg: mem_cmd constants (MNONE, MREAD, MWRITE), pc_sel constants, state enum.
- One sub-module: fetch_pc_reg, parametrised load-enable register with async active-low reset and reset value, used for pc, ir, link.

## Test plan
- Reset, RESET_PC=0, go=1, zero-wait memory word 0=16'hD105 -> mem_cmd=READ addr 0 cycle 1, ir=16'hD105 and ir_valid cycle 2, pc=1, link=1.
- mem_rdy delayed 3 cycles -> READ held 4 cycles at same address, ir_valid once.
- At pc=5 post-fetch, pc_sel=01, off=16'hFFFD -> next fetch address 3; pc=511, pc_sel=00 -> wrap to 0.
- EXEC dat_req=1, dat_we=0, dat_addr=9'h40, mem returns 16'hBEEF after 2 waits -> dat_rdata=16'hBEEF, single dat_done; then dat_we=1 -> mem_cmd=WRITE with dat_wdata.
- pc_sel=11 -> halted=1, mem_cmd=NONE, go ignored; reset low mid-FETCH -> immediate IDLE, pc=RESET_PC.
- FETCH_WDOG_EN, TIMEOUT=15, mem_rdy stuck 0 -> mem_err=1 and HALT after 15 cycles; without macro still waiting at cycle 100.
